// File: rtl/aclk_multi_alarm.sv
// BCD time-of-day clock with N loadable alarms, snooze and a self-timing ring FSM.
// The seconds tick comes from an internal prescaler, so clk can run at any rate.
module aclk_multi_alarm #(
    parameter int CLK_PER_SEC = 10,
    parameter int N_ALARMS    = 4,
    parameter int SNOOZE_MIN  = 5,
    parameter int RING_SECS   = 60,
    localparam int AW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          H_in1,
    input  logic [3:0]          H_in0,
    input  logic [3:0]          M_in1,
    input  logic [3:0]          M_in0,
    input  logic                LD_time,
    input  logic                LD_alarm,
    input  logic [AW-1:0]       alarm_sel,
    input  logic [N_ALARMS-1:0] alarm_en,
    input  logic                STOP_al,
    input  logic                snooze,
    output logic [1:0]          H_out1,
    output logic [3:0]          H_out0,
    output logic [3:0]          M_out1,
    output logic [3:0]          M_out0,
    output logic [3:0]          S_out1,
    output logic [3:0]          S_out0,
    output logic                alarm,
    output logic [AW-1:0]       alarm_id,
    output logic                load_err
);
    localparam int PW  = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam int SNZ = SNOOZE_MIN * 60;
    localparam int RW  = $clog2(RING_SECS + 1);
    localparam int SW  = $clog2(SNZ + 1);

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

    state_t          state, state_n;
    logic [RW-1:0]   ring_cnt, ring_n;
    logic [SW-1:0]   snz_cnt, snz_n;
    logic [AW-1:0]   id_n;
    logic [PW-1:0]   presc;
    logic            tick, val_ok, sel_ok, ld_time_ok, ld_alarm_ok;
    logic [1:0]      n_h1;
    logic [3:0]      n_h0, n_m1, n_m0, n_s1, n_s0;
    logic [13:0]     alarm_t [N_ALARMS];
    logic [N_ALARMS-1:0] hit;
    logic [AW-1:0]   hit_id;

    assign tick   = (presc == PW'(CLK_PER_SEC - 1));
    assign val_ok = (H_in1 <= 2'd2) && (M_in1 <= 4'd5) && (M_in0 <= 4'd9) &&
                    ((H_in1 == 2'd2) ? (H_in0 <= 4'd3) : (H_in0 <= 4'd9));
    assign sel_ok = (32'(alarm_sel) < N_ALARMS);
    assign ld_time_ok  = LD_time && val_ok;
    assign ld_alarm_ok = LD_alarm && !LD_time && val_ok && sel_ok;
    assign alarm = (state == RINGING);

    // Time one second ahead; alarms are matched against this so the ring starts with the display.
    always_comb begin
        n_h1 = H_out1; n_h0 = H_out0; n_m1 = M_out1;
        n_m0 = M_out0; n_s1 = S_out1; n_s0 = S_out0;
        if (S_out0 != 4'd9) n_s0 = S_out0 + 4'd1;
        else begin
            n_s0 = 4'd0;
            if (S_out1 != 4'd5) n_s1 = S_out1 + 4'd1;
            else begin
                n_s1 = 4'd0;
                if (M_out0 != 4'd9) n_m0 = M_out0 + 4'd1;
                else begin
                    n_m0 = 4'd0;
                    if (M_out1 != 4'd5) n_m1 = M_out1 + 4'd1;
                    else begin
                        n_m1 = 4'd0;
                        if (H_out1 == 2'd2 && H_out0 == 4'd3) begin
                            n_h1 = 2'd0; n_h0 = 4'd0;
                        end else if (H_out0 == 4'd9) begin
                            n_h1 = H_out1 + 2'd1; n_h0 = 4'd0;
                        end else n_h0 = H_out0 + 4'd1;
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < N_ALARMS; i++) begin : g_match
        assign hit[i] = alarm_en[i] && (alarm_t[i] == {n_h1, n_h0, n_m1, n_m0});
    end

    always_comb begin
        hit_id = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--)
            if (hit[i]) hit_id = AW'(i);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
            H_out1 <= '0; H_out0 <= '0; M_out1 <= '0;
            M_out0 <= '0; S_out1 <= '0; S_out0 <= '0;
        end else if (ld_time_ok) begin
            presc <= '0;
            H_out1 <= H_in1; H_out0 <= H_in0; M_out1 <= M_in1;
            M_out0 <= M_in0; S_out1 <= '0;    S_out0 <= '0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                H_out1 <= n_h1; H_out0 <= n_h0; M_out1 <= n_m1;
                M_out0 <= n_m0; S_out1 <= n_s1; S_out0 <= n_s0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_ALARMS; i++) alarm_t[i] <= '0;
            load_err <= 1'b0;
        end else begin
            for (int i = 0; i < N_ALARMS; i++)
                if (ld_alarm_ok && alarm_sel == AW'(i))
                    alarm_t[i] <= {H_in1, H_in0, M_in1, M_in0};
            load_err <= LD_time ? !val_ok : (LD_alarm && !(val_ok && sel_ok));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE; ring_cnt <= '0; snz_cnt <= '0; alarm_id <= '0;
        end else begin
            state <= state_n; ring_cnt <= ring_n; snz_cnt <= snz_n; alarm_id <= id_n;
        end
    end

    always_comb begin
        state_n = state; ring_n = ring_cnt; snz_n = snz_cnt; id_n = alarm_id;
        if (ld_time_ok) state_n = IDLE;
        else begin
            case (state)
                IDLE:
                    if (tick && n_s1 == 4'd0 && n_s0 == 4'd0 && |hit) begin
                        state_n = RINGING; id_n = hit_id; ring_n = '0;
                    end
                RINGING:
                    if (STOP_al) state_n = IDLE;
                    else if (snooze) begin
                        state_n = SNOOZED; snz_n = SW'(SNZ);
                    end else if (tick) begin
                        if (ring_cnt == RW'(RING_SECS - 1)) state_n = IDLE;
                        else ring_n = ring_cnt + RW'(1);
                    end
                SNOOZED:
                    if (STOP_al) state_n = IDLE;
                    else if (tick) begin
                        if (snz_cnt == SW'(1)) begin
                            state_n = RINGING; ring_n = '0;
                        end else snz_n = snz_cnt - SW'(1);
                    end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule
